audio_sample_filter: RTL and testbench

Consumes the 10-bit unsigned samples and `valid` strobe produced by the MCP3008 SPI ADC front end. It re-centres each sample to signed and smooths it with a 2^AVG_LOG2-tap moving average, built from a ring buffer and a running sum. It emits one signed, full-scale audio word per accepted sample for the downstream guitar-effect chain. It runs entirely in the CLK50 domain; the ADC strobe arrives from the SCLK-derived domain and is synchronised and edge-detected internally.

---
 rtl/audio_pkg.sv | 15 +
 rtl/audio_sample_filter_strobe_sync.sv | 25 ++
 rtl/audio_sample_filter.sv | 144 ++++++++++++++
 tb/tb_audio_sample_filter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio sample filter and its helpers.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    UPDATE  = 2'd2,
    EMIT    = 2'd3
  } filt_state_t;

  localparam int ADC_N_DEF = 10;
  localparam int ADC_MID   = 512;
  localparam int OUT_W_DEF = 16;

endpackage

// File: rtl/audio_sample_filter_strobe_sync.sv
// Three-flop synchroniser with rising-edge detect for a slow-domain strobe level.
module strobe_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic level_i,
  output logic pulse_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], level_i};

  // Reset to ones so a level already high at reset release is not seen as an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/audio_sample_filter.sv
// Re-centres ADC samples to signed and smooths them with a power-of-two moving average.
module audio_sample_filter
  import audio_pkg::*;
#(
  parameter int ADC_N    = ADC_N_DEF,
  parameter int AVG_LOG2 = 3,
  parameter int OUT_W    = OUT_W_DEF
) (
  input  logic                    CLK50,
  input  logic                    reset,
  input  logic [ADC_N-1:0]        adc_in,
  input  logic                    adc_valid,
  input  logic                    bypass,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    overrun
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = ADC_N + AVG_LOG2;
  localparam int PAD   = OUT_W - ADC_N;

  filt_state_t               state_q, state_d;
  logic signed [ADC_N-1:0]   x_q, x_d;
  logic signed [ADC_N-1:0]   old_q, old_d;
  logic signed [ADC_N-1:0]   buf_q [DEPTH];
  logic [AVG_LOG2-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AVG_LOG2:0]         fill_q, fill_d;
  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic signed [OUT_W-1:0]   sample_out_q, sample_out_d;
  logic                      sample_valid_q, sample_valid_d;
  logic                      overrun_q, overrun_d;
  logic                      buf_we_s;
  logic                      accept_s;
  logic signed [ADC_N-1:0]   avg_s;

  strobe_sync u_sync (
    .clk_i   (CLK50),
    .reset_i (reset),
    .level_i (adc_valid),
    .pulse_o (accept_s)
  );

  // Dropping the low AVG_LOG2 bits is the arithmetic shift; the mean always fits ADC_N bits.
  assign avg_s = sum_q[SUM_W-1:AVG_LOG2];

  // Next-state and datapath control for the capture/update/emit sequence.
  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    old_d          = old_q;
    wr_ptr_d       = wr_ptr_q;
    fill_d         = fill_q;
    sum_d          = sum_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    buf_we_s       = 1'b0;

    if (accept_s && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          // Flipping the MSB subtracts the mid-scale offset.
          x_d     = {~adc_in[ADC_N-1], adc_in[ADC_N-2:0]};
          old_d   = buf_q[wr_ptr_q];
          state_d = CAPTURE;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: state_d = UPDATE;
      UPDATE: begin
        sum_d    = sum_q + {{AVG_LOG2{x_q[ADC_N-1]}}, x_q}
                         - {{AVG_LOG2{old_q[ADC_N-1]}}, old_q};
        wr_ptr_d = wr_ptr_q + {{(AVG_LOG2-1){1'b0}}, 1'b1};
        if (fill_q[AVG_LOG2]) begin
          fill_d = fill_q;
        end else begin
          fill_d = fill_q + {{AVG_LOG2{1'b0}}, 1'b1};
        end
        buf_we_s = 1'b1;
        state_d  = EMIT;
      end
      EMIT: begin
        if (bypass) begin
          sample_out_d = {x_q, {PAD{1'b0}}};
        end else begin
          sample_out_d = {avg_s, {PAD{1'b0}}};
        end
        sample_valid_d = bypass | fill_q[AVG_LOG2];
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK50) begin
    if (reset) begin
      state_q        <= IDLE;
      x_q            <= '0;
      old_q          <= '0;
      wr_ptr_q       <= '0;
      fill_q         <= '0;
      sum_q          <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      old_q          <= old_d;
      wr_ptr_q       <= wr_ptr_d;
      fill_q         <= fill_d;
      sum_q          <= sum_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  // Ring buffer of the last DEPTH centred samples.
  always_ff @(posedge CLK50) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (buf_we_s) begin
      buf_q[wr_ptr_q] <= x_q;
    end else begin
      buf_q[wr_ptr_q] <= buf_q[wr_ptr_q];
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_audio_sample_filter.sv
// Scoreboard bench: stimulus pushes expected outputs, a monitor pops and compares them.
module tb_audio_sample_filter;

  logic               CLK50 = 1'b0;
  logic               reset = 1'b1;
  logic [9:0]         adc_in = 10'd0;
  logic               adc_valid = 1'b0;
  logic               bypass = 1'b0;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int val;
    int at;
  } exp_t;
  exp_t q[$];

  // Reference model of the averager: last 8 centred samples and a fill count.
  int hist [8];
  int mptr  = 0;
  int mfill = 0;

  audio_sample_filter dut (
    .CLK50        (CLK50),
    .reset        (reset),
    .adc_in       (adc_in),
    .adc_valid    (adc_valid),
    .bypass       (bypass),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  always #10 CLK50 = ~CLK50;

  always @(posedge CLK50) cyc <= cyc + 1;

  function automatic int floor_div8(input int s);
    if (s >= 0) return s / 8;
    return -((-s + 7) / 8);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) hist[i] = 0;
    mptr  = 0;
    mfill = 0;
  endtask

  // Returns 1 and the expected word when the model says an output is due.
  task automatic model_step(input int v, input bit byp, output bit emit, output int e);
    int x;
    int s;
    x = v - 512;
    hist[mptr] = x;
    mptr = (mptr + 1) % 8;
    if (mfill < 8) mfill++;
    s = 0;
    for (int i = 0; i < 8; i++) s += hist[i];
    emit = byp || (mfill == 8);
    e = byp ? x * 64 : floor_div8(s) * 64;
  endtask

  task automatic do_reset();
    @(posedge CLK50); #1;
    reset = 1'b1;
    repeat (2) @(posedge CLK50);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // One ADC strobe; a hand-computed value overrides the model when given.
  task automatic strobe(input int v, input bit byp, input bit hand, input int hv);
    bit emit;
    int e;
    exp_t ent;
    @(posedge CLK50); #1;
    adc_in    = v[9:0];
    bypass    = byp;
    adc_valid = 1'b1;
    model_step(v, byp, emit, e);
    if (emit) begin
      ent.val = hand ? hv : e;
      ent.at  = cyc + 6;
      q.push_back(ent);
    end
    repeat (3) @(posedge CLK50);
    #1 adc_valid = 1'b0;
    repeat (5) @(posedge CLK50);
  endtask

  // Monitor: every sample_valid must match the oldest pending expectation.
  always @(negedge CLK50) begin
    if (!reset && sample_valid) begin
      exp_t ent;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got sample_out=%0d at cycle %0d expected no output", sample_out, cyc);
      end else begin
        ent = q.pop_front();
        if ((int'(sample_out) != ent.val) || (cyc != ent.at)) begin
          bad++;
          $display("FAIL sample: got %0d at cycle %0d expected %0d at cycle %0d",
                   sample_out, cyc, ent.val, ent.at);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   emit;
    int   e;
    exp_t ent;

    model_reset();
    repeat (3) @(posedge CLK50);
    #1 reset = 1'b0;
    check("reset_sample_out", int'(sample_out), 0);
    check("reset_sample_valid", int'(sample_valid), 0);
    check("reset_overrun", int'(overrun), 0);

    // Priming: only the eighth strobe produces output.
    for (int i = 0; i < 8; i++) strobe(612, 1'b0, i == 7, 6400);

    // Extremes: ramp down to full negative, then up to full positive.
    for (int i = 0; i < 8; i++) strobe(0, 1'b0, i == 7, -32768);
    for (int i = 0; i < 8; i++) strobe(1023, 1'b0, i == 7, 32704);
    repeat (10) @(posedge CLK50);

    // Bypass straight from reset.
    do_reset();
    strobe(512, 1'b1, 1'b1, 0);
    strobe(513, 1'b1, 1'b1, 64);

    // Overrun: second rising edge two cycles after the first.
    @(posedge CLK50); #1;
    adc_in = 10'd700; bypass = 1'b1; adc_valid = 1'b1;
    model_step(700, 1'b1, emit, e);
    ent.val = 12032;
    ent.at  = cyc + 6;
    q.push_back(ent);
    @(posedge CLK50); #1 adc_valid = 1'b0;
    @(posedge CLK50); #1 adc_valid = 1'b1;
    repeat (3) @(posedge CLK50);
    #1 adc_valid = 1'b0;
    repeat (8) @(posedge CLK50);
    #1 check("overrun_set", int'(overrun), 1);
    strobe(512, 1'b1, 1'b1, 0);
    #1 check("overrun_sticky", int'(overrun), 1);
    do_reset();
    check("overrun_cleared", int'(overrun), 0);

    // adc_valid high across reset release is ignored.
    adc_in = 10'd612; adc_valid = 1'b1;
    do_reset();
    repeat (10) @(posedge CLK50);
    #1 adc_valid = 1'b0;
    repeat (4) @(posedge CLK50);
    strobe(612, 1'b1, 1'b1, 6400);

    // Reset between accept and EMIT aborts the sample.
    @(posedge CLK50); #1;
    adc_in = 10'd900; bypass = 1'b1; adc_valid = 1'b1;
    repeat (2) @(posedge CLK50);
    #1 reset = 1'b1;
    repeat (2) @(posedge CLK50);
    #1 reset = 1'b0; adc_valid = 1'b0;
    model_reset();
    repeat (10) @(posedge CLK50);
    #1 check("abort_sample_out", int'(sample_out), 0);
    check("abort_overrun", int'(overrun), 0);

    // Ramp across the write-pointer wrap with averaging on.
    for (int i = 0; i < 20; i++) strobe(100 + 37 * i, 1'b0, 1'b0, 0);

    repeat (20) @(posedge CLK50);
    check("pending_outputs", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
